// File: rtl/lutram_fifo_ctrl.sv
// FIFO controller for a bank of 32x1 dual-port LUT RAMs: owns pointers, occupancy,
// flags and a first-word-fall-through output register fed from the async read port.
module lutram_fifo_ctrl #(
  parameter int WIDTH       = 8,
  parameter int AW          = 5,
  parameter int AFULL_LEVEL = 30
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             full_o,
  output logic             almost_full_o,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_valid_o,
  output logic [AW:0]      count_o,
  output logic             overflow_o,
  output logic             underflow_o,
  output logic [AW-1:0]    ram_a_o,
  output logic [WIDTH-1:0] ram_d_o,
  output logic             ram_we_o,
  output logic [AW-1:0]    ram_dpra_o,
  input  logic [WIDTH-1:0] ram_dpo_i
);

  localparam int DEPTH = 2 ** AW;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_VALID = 1'b1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      ram_cnt_q, ram_cnt_d;
  logic [AW:0]      count_q, count_d;
  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             full_q, full_d;
  logic             afull_q, afull_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic push, pop, prefetch, valid;

  assign valid    = (state_q == ST_VALID);
  assign push     = wr_en_i & ~full_q;
  assign pop      = rd_en_i & valid;
  // The output register refills whenever it is empty or being drained this edge.
  assign prefetch = (ram_cnt_q != '0) & (~valid | pop);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ram_cnt_d   = ram_cnt_q;
    state_d     = state_q;
    rd_data_d   = rd_data_q;
    overflow_d  = wr_en_i & full_q;
    underflow_d = rd_en_i & ~valid;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    if (prefetch) begin
      rd_data_d = ram_dpo_i;
      rd_ptr_d  = rd_ptr_q + 1'b1;
      state_d   = ST_VALID;
    end else if (pop) begin
      state_d = ST_EMPTY;
    end

    if (push && !prefetch) begin
      ram_cnt_d = ram_cnt_q + 1'b1;
    end else if (!push && prefetch) begin
      ram_cnt_d = ram_cnt_q - 1'b1;
    end

    count_d = ram_cnt_d + {{AW{1'b0}}, (state_d == ST_VALID)};
    full_d  = (ram_cnt_d == (AW+1)'(DEPTH));
    afull_d = (count_d >= (AW+1)'(AFULL_LEVEL));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_cnt_q   <= '0;
      count_q     <= '0;
      state_q     <= ST_EMPTY;
      rd_data_q   <= '0;
      full_q      <= 1'b0;
      afull_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_cnt_q   <= ram_cnt_d;
      count_q     <= count_d;
      state_q     <= state_d;
      rd_data_q   <= rd_data_d;
      full_q      <= full_d;
      afull_q     <= afull_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign full_o        = full_q;
  assign almost_full_o = afull_q;
  assign rd_data_o     = rd_data_q;
  assign rd_valid_o    = valid;
  assign count_o       = count_q;
  assign overflow_o    = overflow_q;
  assign underflow_o   = underflow_q;
  assign ram_a_o       = wr_ptr_q;
  assign ram_d_o       = wr_data_i;
  assign ram_we_o      = wr_en_i & ~full_q & rst_ni;
  assign ram_dpra_o    = rd_ptr_q;

endmodule
